// File: rtl/carry8_seq_pkg.sv
// carry8_seq_pkg: shared types, slice width and counter sizing for the sequential CARRY8 adder
package carry8_seq_pkg;
  localparam int SLICE_W = 8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction
endpackage

// File: rtl/carry8_slice.sv
// carry8_slice: one combinational CARRY8 primitive (S=x^y, DI=x, CI=ci) with its top two carry-outs
module carry8_slice
  import carry8_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] i_x,
  input  logic [SLICE_W-1:0] i_y,
  input  logic               i_ci,
  output logic [SLICE_W-1:0] o_o,
  output logic               o_co7,
  output logic               o_co6
);
  logic [SLICE_W-1:0] w_s;
  logic [SLICE_W:0]   w_c;
  assign w_s = i_x ^ i_y;
  // propagate when S is set, otherwise generate/kill from DI
  always_comb begin
    w_c[0] = i_ci;
    for (int i = 0; i < SLICE_W; i++) w_c[i+1] = w_s[i] ? w_c[i] : i_x[i];
  end
  assign o_o   = w_s ^ w_c[SLICE_W-1:0];
  assign o_co7 = w_c[SLICE_W];
  assign o_co6 = w_c[SLICE_W-1];
endmodule

// File: rtl/carry8_seq_adder.sv
// carry8_seq_adder: WIDTH-bit add/sub computed one byte per cycle through a single shared CARRY8 slice
module carry8_seq_adder
  import carry8_seq_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op_sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);
  localparam int N  = WIDTH / SLICE_W;
  localparam int CW = clog2_min1(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH < SLICE_W || WIDTH % SLICE_W != 0) begin : g_bad_width
    $error("carry8_seq_adder: WIDTH must be a positive multiple of 8");
  end

  state_t r_state, w_next;
  logic [WIDTH-1:0] r_opa, r_opb, r_sum;
  logic             r_carry, r_cout, r_ovf;
  logic [CW-1:0]    r_cnt;
  logic [SLICE_W-1:0] w_o;
  logic w_co7, w_co6, w_acc, w_last;

  carry8_slice u_slice (
    .i_x   (r_opa[SLICE_W-1:0]),
    .i_y   (r_opb[SLICE_W-1:0]),
    .i_ci  (r_carry),
    .o_o   (w_o),
    .o_co7 (w_co7),
    .o_co6 (w_co6)
  );

  always_comb begin
    in_ready  = r_state == IDLE;
    out_valid = r_state == DONE;
    busy      = r_state != IDLE;
    w_acc     = in_valid && r_state == IDLE;
    w_last    = r_cnt == LAST;
    w_next    = w_acc                                ? RUN  :
                (r_state == RUN && w_last)           ? DONE :
                (r_state == DONE && out_ready)       ? IDLE : r_state;
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_opa   <= '0;
      r_opb   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_opa   <= a;
        r_opb   <= op_sub ? ~b : b;
        r_carry <= cin ^ op_sub;
        r_cnt   <= '0;
      end else if (r_state == RUN) begin
        // each result byte enters at the top so byte 0 lands at the bottom after N steps
        r_sum   <= (r_sum >> SLICE_W) | (WIDTH'(w_o) << (WIDTH - SLICE_W));
        r_opa   <= r_opa >> SLICE_W;
        r_opb   <= r_opb >> SLICE_W;
        r_carry <= w_co7;
        r_cnt   <= r_cnt + 1'b1;
        if (w_last) begin
          r_cout <= w_co7;
          r_ovf  <= w_co7 ^ w_co6;
        end
      end
    end
  end
endmodule
